// File: rtl/mux_rr_buffered.sv
// CH-to-1 channel selector with valid/ready handshakes and a one-entry output register.
// Grant comes from an external select (mode 0) or a round-robin search after ptr (mode 1).
module mux_rr_buffered #(
    parameter int unsigned N  = 8,
    parameter int unsigned CH = 16,
    localparam int unsigned SW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [CH*N-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    output logic [CH-1:0]   in_ready,
    output logic [N-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_chan
);

    logic [N-1:0]  words [CH];
    logic [N-1:0]  out_data_q;
    logic [SW-1:0] out_chan_q;
    logic          out_valid_q;
    logic [SW-1:0] ptr_q;

    logic          gnt_found;
    logic [SW-1:0] gnt_idx;
    logic          can_load;
    logic          xfer_in;
    int unsigned   cand;

    always_comb begin
        for (int k = 0; k < CH; k++) begin
            words[k] = in_data[k*N +: N];
        end
    end

    // Grant is recomputed every cycle from current inputs; nothing is held across cycles.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        if (!mode) begin
            if (32'(sel) < CH) begin
                if (in_valid[sel]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = sel;
                end
            end
        end else begin
            for (int unsigned off = 1; off <= CH; off++) begin
                cand = (32'(ptr_q) + off) % CH;
                if (!gnt_found && in_valid[cand[SW-1:0]]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand[SW-1:0];
                end
            end
        end
    end

    // rst_n gates can_load so no in_ready is raised while reset is asserted.
    assign can_load = rst_n & (~out_valid_q | out_ready);
    assign xfer_in  = can_load & gnt_found;
    assign in_ready = xfer_in ? (CH'(1) << gnt_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SW'(CH - 1);
        end else if (xfer_in) begin
            out_data_q  <= words[gnt_idx];
            out_chan_q  <= gnt_idx;
            out_valid_q <= 1'b1;
            if (mode) begin
                ptr_q <= gnt_idx;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_buffered.sv
// Randomised and directed bench for mux_rr_buffered: a driver pushes expected words into a
// scoreboard queue, and a monitor pops and compares on every output handshake.
module tb_mux_rr_buffered;

    localparam int CH = 16;
    localparam int N  = 8;
    localparam int SW = $clog2(CH);

    typedef struct packed {
        logic [N-1:0]  data;
        logic [SW-1:0] chan;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            mode = 1'b0;
    logic [SW-1:0]   sel = '0;
    logic [CH*N-1:0] in_data = '0;
    logic [CH-1:0]   in_valid = '0;
    logic [CH-1:0]   in_ready;
    logic [N-1:0]    out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [SW-1:0]   out_chan;

    int errors = 0;
    int checks = 0;

    exp_t          exp_q[$];
    int            out_log[$];
    logic          m_valid;
    int            m_ptr;
    logic [CH-1:0] last_rdy;

    mux_rr_buffered #(.N(N), .CH(CH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .sel      (sel),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_chan (out_chan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference grant straight from the selection rules.
    function automatic void ref_grant(input logic md, input int s, input logic [CH-1:0] v,
                                      input int p, output bit found, output int g);
        found = 0;
        g     = 0;
        if (!md) begin
            if (s < CH && v[s]) begin
                found = 1;
                g     = s;
            end
        end else begin
            for (int off = 1; off <= CH; off++) begin
                int k;
                k = (p + off) % CH;
                if (!found && v[k]) begin
                    found = 1;
                    g     = k;
                end
            end
        end
    endfunction

    function automatic logic [CH*N-1:0] data_pattern(input int kind);
        logic [CH*N-1:0] d;
        for (int k = 0; k < CH; k++) begin
            if (kind == 0) d[k*N +: N] = N'(k);
            else if (kind == 1) d[k*N +: N] = N'(8'h80 | k);
            else d[k*N +: N] = N'($urandom);
        end
        return d;
    endfunction

    // One clock cycle, entered and left at posedge+2.
    task automatic cycle(input logic md, input int s, input logic [CH-1:0] v,
                         input logic [CH*N-1:0] d, input logic ordy);
        bit            f;
        int            g;
        bit            can;
        logic [CH-1:0] exp_rdy;
        exp_t          e;
        mode      = md;
        sel       = SW'(s);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        ref_grant(md, s, v, m_ptr, f, g);
        can     = !m_valid || ordy;
        exp_rdy = '0;
        if (can && f) exp_rdy[g] = 1'b1;
        last_rdy = in_ready;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        if (can && f) begin
            e.data = d[g*N +: N];
            e.chan = g[SW-1:0];
            exp_q.push_back(e);
            m_valid = 1'b1;
            if (md) m_ptr = g;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        #2;
    endtask

    task automatic drain();
        cycle(1'b0, 0, '0, '0, 1'b1);
        cycle(1'b0, 0, '0, '0, 1'b1);
    endtask

    task automatic chk_log(input string name, input int exp[$]);
        chk({name, "_len"}, 64'(out_log.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < out_log.size()) chk(name, 64'(out_log[i]), 64'(exp[i]));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0) begin
                chk("out_data", 64'(out_data), 64'(exp_q[0].data));
                chk("out_chan", 64'(out_chan), 64'(exp_q[0].chan));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    out_log.push_back(int'(out_chan));
                end
            end
        end
    end

    initial begin
        logic [CH*N-1:0] d;
        logic [N-1:0]    held_data;
        logic [SW-1:0]   held_chan;
        int              exp_seq[$];

        m_valid = 1'b0;
        m_ptr   = CH - 1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        #12 rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Fixed select.
        d = data_pattern(2);
        d[5*N +: N] = 8'hA5;
        cycle(1'b0, 5, 16'h0020, d, 1'b1);
        chk("fix_rdy5", 64'(last_rdy), 64'h0020);
        chk("fix_data", 64'(out_data), 64'hA5);
        chk("fix_chan", 64'(out_chan), 64'd5);
        chk("fix_valid", 64'(out_valid), 64'd1);
        cycle(1'b0, 6, 16'h0020, d, 1'b1);
        chk("fix_rdy6", 64'(last_rdy), 64'h0);
        drain();

        // Round-robin fairness.
        out_log.delete();
        for (int i = 0; i < 32; i++) cycle(1'b1, 0, '1, data_pattern(0), 1'b1);
        drain();
        exp_seq.delete();
        for (int i = 0; i < 32; i++) exp_seq.push_back(i % CH);
        chk_log("rr_fair", exp_seq);

        // Sparse round-robin with wrap.
        out_log.delete();
        for (int i = 0; i < 6; i++) cycle(1'b1, 0, 16'h8101, data_pattern(2), 1'b1);
        drain();
        exp_seq = '{0, 8, 15, 0, 8, 15};
        chk_log("rr_sparse", exp_seq);

        // Back-pressure: hold, then drain and reload together.
        cycle(1'b1, 0, '1, data_pattern(1), 1'b1);
        held_data = out_data;
        held_chan = out_chan;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 0, '1, data_pattern(2), 1'b0);
            chk("bp_rdy", 64'(last_rdy), 64'h0);
            chk("bp_data", 64'(out_data), 64'(held_data));
            chk("bp_chan", 64'(out_chan), 64'(held_chan));
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 0, '1, data_pattern(2), 1'b1);
            chk("bp_valid", 64'(out_valid), 64'd1);
        end
        drain();

        // Mode switch leaves ptr alone.
        out_log.delete();
        cycle(1'b1, 0, 16'h0008, data_pattern(2), 1'b1);
        cycle(1'b0, 9, '1, data_pattern(2), 1'b1);
        cycle(1'b1, 0, '1, data_pattern(2), 1'b1);
        drain();
        exp_seq = '{3, 9, 4};
        chk_log("mode_sw", exp_seq);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [CH-1:0] v;
            case ($urandom_range(0, 3))
                0:       v = '1;
                1:       v = CH'($urandom) & CH'($urandom) & CH'($urandom);
                default: v = CH'($urandom);
            endcase
            cycle(1'(($urandom_range(0, 1))), $urandom_range(0, CH - 1), v,
                  data_pattern(2), 1'($urandom_range(0, 9) < 7));
        end
        drain();

        // Reset mid-stream with a held word.
        cycle(1'b1, 0, '1, data_pattern(1), 1'b0);
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_data", 64'(out_data), 64'd0);
        chk("mrst_chan", 64'(out_chan), 64'd0);
        chk("mrst_rdy", 64'(in_ready), 64'd0);
        exp_q.delete();
        m_valid = 1'b0;
        m_ptr   = CH - 1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_edge_valid", 64'(out_valid), 64'd0);
        #1 rst_n = 1'b1;
        out_log.delete();
        cycle(1'b1, 0, '1, data_pattern(1), 1'b1);
        drain();
        exp_seq = '{0};
        chk_log("post_rst", exp_seq);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
